alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width.
REQ-002 SHALL have parameter IDLE_CYCLES, default 4, consecutive idle cycles before sleep; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_op input 4, cmd_a input WIDTH, cmd_b input WIDTH; command channel.
REQ-006 SHALL have ports alu_op output 4, alu_a output WIDTH, alu_b output WIDTH; registered drive into the combinational ALU.
REQ-007 SHALL have port alu_result  input  WIDTH  combinational ALU output for current alu_op/alu_a/alu_b.
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_result output WIDTH, rsp_err output 1; response channel.
REQ-009 SHALL have port alu_clk_en  output  1  registered enable for the ALU clock gate.

Function
REQ-010 SHALL implement states IDLE, EXEC, RESP, plus SLEEP when ALU_CLKGATE_EN is defined.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 at a clock edge.
REQ-012 On acceptance SHALL register cmd_op/cmd_a/cmd_b into alu_op/alu_a/alu_b and go IDLE->EXEC.
REQ-013 alu_op/alu_a/alu_b SHALL change only on acceptance and otherwise hold, minimising ALU input toggling.
REQ-014 In EXEC SHALL capture alu_result into rsp_result, set rsp_err = alu_op[3], and go EXEC->RESP unconditionally.
REQ-015 When alu_op[3]=1 (undefined op), rsp_result SHALL be 0 regardless of alu_result.
REQ-016 rsp_valid SHALL be 1 exactly in RESP; latency from acceptance edge to rsp_valid=1 is 2 cycles.
REQ-017 In RESP, rsp_valid/rsp_result/rsp_err SHALL hold stable until rsp_ready=1; then go RESP->IDLE.
REQ-018 rsp_result and rsp_err SHALL hold their last value after the handshake until the next EXEC.
REQ-019 Maximum throughput SHALL be one command per 3 cycles with rsp_ready held 1; no command overlap, no buffering.
REQ-020 cmd_valid during EXEC/RESP SHALL be ignored (not accepted, not lost by the block; the sender holds it).

Reset
REQ-021 On rst=1 at a clock edge: state IDLE; cmd_ready=1; rsp_valid=0; rsp_err=0; rsp_result=0; alu_op/alu_a/alu_b=0; alu_clk_en=1; idle counter=0.
REQ-022 rst SHALL override all other inputs; reset in EXEC or RESP SHALL discard the pending response without a handshake.

Configuration
REQ-023 Macro ALU_CLKGATE_EN SHALL control sleep/clock-gating.
REQ-024 Defined: an idle counter SHALL count consecutive IDLE cycles with cmd_valid=0, clearing on cmd_valid=1 or leaving IDLE.
REQ-025 Defined: after IDLE_CYCLES such cycles SHALL go IDLE->SLEEP; in SLEEP alu_clk_en=0 and cmd_ready=0.
REQ-026 Defined: cmd_valid=1 in SLEEP SHALL set alu_clk_en=1 and go SLEEP->IDLE at the next edge; the command is accepted no earlier than the following edge (1-cycle wake penalty).
REQ-027 Defined: alu_clk_en SHALL be 1 in IDLE, EXEC and RESP.
REQ-028 Undefined: no SLEEP state, no idle counter; alu_clk_en constant 1; REQ-011..020 unchanged.

Verification
REQ-029 Add: reset, cmd op=0000 a=8'h05 b=8'h03, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_result=8'h08, rsp_err=0.
REQ-030 Backpressure: op=0001 a=8'h10 b=8'h01, rsp_ready=0 for 5 cycles -> rsp_valid/rsp_result=8'h0F stable 5 cycles, cmd_ready=0 throughout; IDLE the cycle after rsp_ready=1.
REQ-031 Undefined op: op=1010 a=8'hFF b=8'hFF -> rsp_result=8'h00, rsp_err=1.
REQ-032 Back-to-back: 3 commands with cmd_valid held, rsp_ready=1 -> accepts spaced exactly 3 cycles, alu_a/alu_b change only at accept edges.
REQ-033 Sleep (ALU_CLKGATE_EN, IDLE_CYCLES=4): 4 idle cycles -> alu_clk_en=0; then op=0010 a=8'hF0 b=8'h3C -> wake cycle, accept next edge, rsp_result=8'h30; without macro alu_clk_en stays 1.
REQ-034 Reset mid-op: assert rst in EXEC -> next cycle rsp_valid=0, cmd_ready=1, alu_a=0, no response delivered.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Purpose: issues one command at a time into an external combinational ALU and returns its result.
// Latency: rsp_valid rises two cycles after the cycle in which cmd_valid/cmd_ready handshake (3-cycle issue interval).
// Backpressure: no buffering; cmd_ready drops until the response handshakes, and the response holds while rsp_ready=0.
//
// Ports:
//   clk, rst                          - single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b - command channel (valid/ready)
//   alu_op/alu_a/alu_b                - registered operands into the ALU, updated only on command accept
//   alu_result                        - combinational ALU output for the current alu_op/alu_a/alu_b
//   rsp_valid/rsp_ready/rsp_result/rsp_err - response channel (valid/ready)
//   alu_clk_en                        - registered enable for the ALU clock gate
//
// Build option: define ALU_CLKGATE_EN to add the SLEEP state, the idle counter and
// clock-gate control. Without it alu_clk_en is tied high and the FSM is IDLE/EXEC/RESP.

module alu_issue_ctrl #(
    parameter int WIDTH       = 8,
    parameter int IDLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,

    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,

    output logic             alu_clk_en
);

    // Elaboration-time guard: the idle counter is 8 bits wide.
    if ((IDLE_CYCLES < 1) || (IDLE_CYCLES > 255)) begin : g_bad_idle_cycles
        $error("alu_issue_ctrl: IDLE_CYCLES must be within 1..255");
    end

`ifdef ALU_CLKGATE_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        RESP  = 2'd2,
        SLEEP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        RESP  = 2'd2
    } state_t;
`endif

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   do_exec;

`ifdef ALU_CLKGATE_EN
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);

    logic [7:0] idle_cnt;
    logic       idle_expired;

    // True during the last idle cycle before sleeping; the transition
    // itself happens on the edge that ends this cycle.
    assign idle_expired = (idle_cnt == IDLE_LAST);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
`ifdef ALU_CLKGATE_EN
                else if (idle_expired) begin
                    state_d = SLEEP;
                end
`endif
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef ALU_CLKGATE_EN
            SLEEP: begin
                // Wake only; the command is taken from IDLE on the
                // following edge, so the sender simply keeps cmd_valid up.
                if (cmd_valid) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign do_exec = (state_q == EXEC);

    // ------------------------------------------------------------------
    // Datapath: ALU operand registers load only on accept so the ALU
    // inputs stay quiet between commands; the response registers load
    // only in EXEC and otherwise keep their last value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_op <= cmd_op;
                alu_a  <= cmd_a;
                alu_b  <= cmd_b;
            end
            if (do_exec) begin
                // op[3] marks an undefined operation: flag it and return
                // zero whatever the ALU happens to produce.
                rsp_err    <= alu_op[3];
                rsp_result <= alu_op[3] ? '0 : alu_result;
            end
        end
    end

`ifdef ALU_CLKGATE_EN
    // ------------------------------------------------------------------
    // Idle counter: consecutive IDLE cycles with no command pending.
    // Cleared by any cmd_valid and by leaving IDLE (including to SLEEP).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state_q == IDLE) && !cmd_valid && (state_d == IDLE)) begin
            idle_cnt <= idle_cnt + 8'd1;
        end else begin
            idle_cnt <= '0;
        end
    end

    // Registered from the next state so the gate enable lines up with
    // the state it belongs to: low exactly while in SLEEP.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_clk_en <= 1'b1;
        end else begin
            alu_clk_en <= (state_d != SLEEP);
        end
    end
`else
    assign alu_clk_en = 1'b1;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: drives commands, models the external ALU,
// and checks responses against a queue of expected results.
// Works with or without ALU_CLKGATE_EN defined.

module tb_alu_issue_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;
    logic             alu_clk_en;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    // Expected responses: {err, result}
    logic [WIDTH:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in combinational ALU; undefined ops return a non-zero pattern
    // so that zeroing by the controller is observable.
    always_comb begin
        case (alu_op)
            4'h0:    alu_result = alu_a + alu_b;
            4'h1:    alu_result = alu_a - alu_b;
            4'h2:    alu_result = alu_a & alu_b;
            4'h3:    alu_result = alu_a | alu_b;
            default: alu_result = 8'hA5;
        endcase
    end

    alu_issue_ctrl #(
        .WIDTH       (WIDTH),
        .IDLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_clk_en (alu_clk_en)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic present(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] er, input logic ee);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        exp_q.push_back({ee, er});
    endtask

    // Call from just after a rising edge. Returns the cycle number seen in
    // the handshake cycle and drops cmd_valid after the accepting edge.
    task automatic wait_accept(output int hs, output bit ok);
        ok = 1'b0;
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                hs = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Reset must win over an active command.
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'h3; cmd_a = 8'hAA; cmd_b = 8'h55; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++;
        if ({rsp_err, rsp_result} !== 9'h000) begin miscompares++; $display("FAIL reset_rsp: got err=%b res=%h expected 0/00", rsp_err, rsp_result); end
        vectors++;
        if ({alu_op, alu_a, alu_b} !== 20'h0) begin miscompares++; $display("FAIL reset_alu_regs: got %h/%h/%h expected 0/00/00", alu_op, alu_a, alu_b); end
        vectors++;
        if (alu_clk_en !== 1'b1) begin miscompares++; $display("FAIL reset_clk_en: got %b expected 1", alu_clk_en); end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_add();
        int hs, at; bit ok, ok2; logic [WIDTH:0] e;
        rsp_ready = 1'b1;
        present(4'b0000, 8'h05, 8'h03, 8'h08, 1'b0);
        wait_accept(hs, ok);
        wait_rsp(at, ok2);
        vectors++;
        if (!ok || !ok2) begin miscompares++; $display("FAIL add_handshake: got accept=%b rsp=%b expected 1/1", ok, ok2); end
        vectors++;
        if (at - hs !== 2) begin miscompares++; $display("FAIL add_latency: got %0d expected 2", at - hs); end
        e = exp_q.pop_front();
        vectors++;
        if ({rsp_err, rsp_result} !== e) begin miscompares++; $display("FAIL add_result: got err=%b res=%h expected err=%b res=%h", rsp_err, rsp_result, e[8], e[7:0]); end
        vectors++;
        if (rsp_result !== 8'h08) begin miscompares++; $display("FAIL add_value: got %h expected 08", rsp_result); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, cmd_ready, rsp_result} !== {1'b0, 1'b1, 8'h08}) begin
            miscompares++; $display("FAIL add_after: got valid=%b ready=%b res=%h expected 0/1/08", rsp_valid, cmd_ready, rsp_result);
        end
    endtask

    task automatic test_backpressure();
        int hs, at; bit ok, ok2; logic [WIDTH:0] e;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        present(4'b0001, 8'h10, 8'h01, 8'h0F, 1'b0);
        wait_accept(hs, ok);
        // A second command held during EXEC/RESP must be ignored.
        cmd_valid = 1'b1; cmd_op = 4'h3; cmd_a = 8'h77; cmd_b = 8'h66;
        wait_rsp(at, ok2);
        vectors++;
        if (!ok || !ok2) begin miscompares++; $display("FAIL bp_handshake: got accept=%b rsp=%b expected 1/1", ok, ok2); end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({rsp_valid, rsp_result, rsp_err, cmd_ready, alu_a} !== {1'b1, 8'h0F, 1'b0, 1'b0, 8'h10}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b res=%h err=%b ready=%b alu_a=%h expected 1/0f/0/0/10",
                         k, rsp_valid, rsp_result, rsp_err, cmd_ready, alu_a);
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        vectors++;
        if ({rsp_err, rsp_result} !== e) begin miscompares++; $display("FAIL bp_result: got err=%b res=%h expected err=%b res=%h", rsp_err, rsp_result, e[8], e[7:0]); end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_undef_op();
        int hs, at; bit ok, ok2; logic [WIDTH:0] e;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        present(4'b1010, 8'hFF, 8'hFF, 8'h00, 1'b1);
        wait_accept(hs, ok);
        wait_rsp(at, ok2);
        vectors++;
        if (!ok || !ok2) begin miscompares++; $display("FAIL undef_handshake: got accept=%b rsp=%b expected 1/1", ok, ok2); end
        e = exp_q.pop_front();
        vectors++;
        if ({rsp_err, rsp_result} !== e) begin miscompares++; $display("FAIL undef_result: got err=%b res=%h expected err=%b res=%h", rsp_err, rsp_result, e[8], e[7:0]); end
        @(posedge clk); #1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_result} !== {1'b0, 1'b1, 8'h00}) begin
            miscompares++; $display("FAIL undef_hold: got valid=%b err=%b res=%h expected 0/1/00", rsp_valid, rsp_err, rsp_result);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3] = '{4'h0, 4'h1, 4'h3};
        logic [7:0] as  [3] = '{8'h01, 8'h09, 8'hF0};
        logic [7:0] bs  [3] = '{8'h02, 8'h04, 8'h0F};
        logic [7:0] rs  [3] = '{8'h03, 8'h05, 8'hFF};
        int idx = 0, got = 0, accepts = 0, last_hs = -1;
        bit prev_hs = 1'b0, hs = 1'b0;
        logic [7:0] pa, pb;
        logic [WIDTH:0] e;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        present(ops[0], as[0], bs[0], rs[0], 1'b0);
        idx = 1;
        pa = alu_a; pb = alu_b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (((alu_a !== pa) || (alu_b !== pb)) && !prev_hs) begin
                miscompares++; $display("FAIL b2b_alu_hold: got %h/%h expected %h/%h", alu_a, alu_b, pa, pb);
            end
            pa = alu_a; pb = alu_b;
            if (rsp_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++; $display("FAIL b2b_extra_rsp: got res=%h expected none", rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    vectors++;
                    if ({rsp_err, rsp_result} !== e) begin miscompares++; $display("FAIL b2b_result: got err=%b res=%h expected err=%b res=%h", rsp_err, rsp_result, e[8], e[7:0]); end
                end
            end
            hs = cmd_valid && cmd_ready;
            if (hs) begin
                accepts++;
                if (last_hs >= 0) begin
                    vectors++;
                    if (cyc - last_hs !== 3) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 3", cyc - last_hs); end
                end
                last_hs = cyc;
            end
            prev_hs = hs;
            if (got == 3) break;
            @(posedge clk); #1;
            if (hs) begin
                if (idx < 3) begin
                    present(ops[idx], as[idx], bs[idx], rs[idx], 1'b0);
                    idx++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        vectors++;
        if ((accepts !== 3) || (got !== 3)) begin miscompares++; $display("FAIL b2b_count: got accepts=%0d rsps=%0d expected 3/3", accepts, got); end
        @(posedge clk); #1;
    endtask

    task automatic test_sleep();
        int hs, at; bit ok, ok2; logic [WIDTH:0] e;
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef ALU_CLKGATE_EN
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({alu_clk_en, cmd_ready} !== 2'b11) begin miscompares++; $display("FAIL sleep_3idle: got en=%b ready=%b expected 1/1", alu_clk_en, cmd_ready); end
        @(negedge clk);
        vectors++;
        if ({alu_clk_en, cmd_ready} !== 2'b00) begin miscompares++; $display("FAIL sleep_entry: got en=%b ready=%b expected 0/0", alu_clk_en, cmd_ready); end
        present(4'b0010, 8'hF0, 8'h3C, 8'h30, 1'b0);
        @(negedge clk);
        vectors++;
        if ({alu_clk_en, cmd_ready, alu_a} !== {1'b1, 1'b1, 8'h00}) begin
            miscompares++; $display("FAIL sleep_wake: got en=%b ready=%b alu_a=%h expected 1/1/00", alu_clk_en, cmd_ready, alu_a);
        end
        ok = cmd_valid && cmd_ready;
        hs = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
`else
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({alu_clk_en, cmd_ready} !== 2'b11) begin miscompares++; $display("FAIL nosleep_idle[%0d]: got en=%b ready=%b expected 1/1", k, alu_clk_en, cmd_ready); end
        end
        @(posedge clk); #1;
        present(4'b0010, 8'hF0, 8'h3C, 8'h30, 1'b0);
        wait_accept(hs, ok);
`endif
        wait_rsp(at, ok2);
        vectors++;
        if (!ok || !ok2) begin miscompares++; $display("FAIL sleep_handshake: got accept=%b rsp=%b expected 1/1", ok, ok2); end
        vectors++;
        if (at - hs !== 2) begin miscompares++; $display("FAIL sleep_latency: got %0d expected 2", at - hs); end
        e = exp_q.pop_front();
        vectors++;
        if ({rsp_err, rsp_result} !== e) begin miscompares++; $display("FAIL sleep_result: got err=%b res=%h expected err=%b res=%h", rsp_err, rsp_result, e[8], e[7:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int hs; bit ok; bit seen = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_op = 4'h0; cmd_a = 8'h33; cmd_b = 8'h11; cmd_valid = 1'b1;
        wait_accept(hs, ok);
        @(negedge clk);
        vectors++;
        if (!ok || ({cmd_ready, rsp_valid, alu_a} !== {1'b0, 1'b0, 8'h33})) begin
            miscompares++; $display("FAIL midrst_exec: got accept=%b ready=%b valid=%b alu_a=%h expected 1/0/0/33", ok, cmd_ready, rsp_valid, alu_a);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, cmd_ready, alu_a} !== {1'b0, 1'b1, 8'h00}) begin
            miscompares++; $display("FAIL midrst_after: got valid=%b ready=%b alu_a=%h expected 0/1/00", rsp_valid, cmd_ready, alu_a);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_no_rsp: got response=%b expected 0", seen); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_backpressure();
        test_undef_op();
        test_back_to_back();
        test_sleep();
        test_reset_mid_op();
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
